// File: rtl/ibex_trace_capture_ctrl.sv
// ibex_trace_capture_ctrl
//   Triggered capture controller for the RVFI retirement stream. An arm/trigger/stop
//   FSM decides which retirements are captured. Captured records go into a FIFO that
//   a single valid/ready trace sink drains. Records that arrive while the FIFO is full
//   are counted as drops.
//
//   Optional feature (macro IBEX_TRACE_CAPTURE_TS_EN): a free-running 32-bit cycle
//   counter. Its value in the push cycle becomes the record MSBs (record width 134).
//   When the macro is undefined there is no counter and the record width is 102.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   rvfi_*                 retirement record inputs (valid, pc, insn, trap, rd addr/data)
//   arm_i, stop_i          control pulses (arm from IDLE; stop capture or disarm)
//   trig_any_i, trig_pc_i  trigger select: first retirement, or retirement at trig_pc_i
//   trace_valid_o/ready_i  sink handshake for the FIFO head
//   trace_rec_o            head record {[ts,] trap, rd_wdata, rd_addr, insn, pc}
//   state_o                IDLE=0 ARMED=1 CAPTURE=2 DRAIN=3
//   drop_cnt_o             saturating count of records lost to a full FIFO
//   overflow_o             sticky drop flag, cleared on arm
module ibex_trace_capture_ctrl #(
    parameter int unsigned Depth      = 8,
    parameter int unsigned CaptureLen = 0,
    parameter int unsigned DropCntW   = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rvfi_valid,
    input  logic [31:0]         rvfi_pc_rdata,
    input  logic [31:0]         rvfi_insn,
    input  logic                rvfi_trap,
    input  logic [4:0]          rvfi_rd_addr,
    input  logic [31:0]         rvfi_rd_wdata,
    input  logic                arm_i,
    input  logic                stop_i,
    input  logic                trig_any_i,
    input  logic [31:0]         trig_pc_i,
    output logic                trace_valid_o,
    input  logic                trace_ready_i,
`ifdef IBEX_TRACE_CAPTURE_TS_EN
    output logic [133:0]        trace_rec_o,
`else
    output logic [101:0]        trace_rec_o,
`endif
    output logic [1:0]          state_o,
    output logic [DropCntW-1:0] drop_cnt_o,
    output logic                overflow_o
);

`ifdef IBEX_TRACE_CAPTURE_TS_EN
    localparam int unsigned RW = 134;
`else
    localparam int unsigned RW = 102;
`endif
    localparam int unsigned AW = $clog2(Depth);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    state_e                state_q;
    logic [RW-1:0]         mem_q [Depth];
    logic [AW:0]           wptr_q, rptr_q;
    logic [31:0]           cap_cnt_q;
    logic [DropCntW-1:0]   drop_cnt_q;
    logic                  overflow_q;

    logic                  empty, full, pop, push_req, push, drop;
    logic                  is_trig, cap_open, len_hit;
    logic [31:0]           cap_cnt_inc;
    logic [RW-1:0]         push_rec;

`ifdef IBEX_TRACE_CAPTURE_TS_EN
    logic [31:0] ts_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    assign push_rec = {ts_q, rvfi_trap, rvfi_rd_wdata, rvfi_rd_addr, rvfi_insn, rvfi_pc_rdata};
`else
    assign push_rec = {rvfi_trap, rvfi_rd_wdata, rvfi_rd_addr, rvfi_insn, rvfi_pc_rdata};
`endif

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = !empty && trace_ready_i;

    assign is_trig     = rvfi_valid && (trig_any_i || (rvfi_pc_rdata == trig_pc_i));
    assign cap_cnt_inc = (cap_cnt_q == '1) ? cap_cnt_q : cap_cnt_q + 32'd1;
    // With a length limit, capture stays open only while the limit is not yet reached.
    assign cap_open    = (CaptureLen == 0) || (cap_cnt_q < CaptureLen);
    assign len_hit     = (CaptureLen != 0) && (cap_cnt_inc >= CaptureLen);

    // Stop beats a same-cycle trigger in ARMED, but not a same-cycle retirement in CAPTURE.
    assign push_req = ((state_q == ARMED) && !stop_i && is_trig) ||
                      ((state_q == CAPTURE) && rvfi_valid && cap_open);
    assign push     = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= push_rec;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cap_cnt_q  <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
            if (push_req) begin
                cap_cnt_q <= cap_cnt_inc;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + DropCntW'(1);
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        state_q    <= ARMED;
                        cap_cnt_q  <= '0;
                        drop_cnt_q <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        state_q <= IDLE;
                    end else if (is_trig) begin
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (stop_i || !cap_open || (push_req && len_hit)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (empty) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign trace_valid_o = !empty;
    assign trace_rec_o   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign state_o       = state_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign overflow_o    = overflow_q;

endmodule
